// File: rtl/fwrisc_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the RVC length test.
package fwrisc_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH       = 2'd0,
    FETCH2      = 2'd1,
    WAIT_DECODE = 2'd2
  } fetch_state_e;

  // Low two bits of a halfword equal to this mark a 32-bit instruction.
  localparam logic [1:0] RVC_LEN32 = 2'b11;

  function automatic logic is_32bit(input logic [15:0] h);
    return h[1:0] == RVC_LEN32;
  endfunction

endpackage

// File: rtl/fwrisc_fetch.sv
// Instruction fetch: word-aligned bus requests, RVC halfword extraction,
// straddling 32-bit assembly and a one-halfword hold buffer so sequential
// compressed code does not refetch the upper half of a word already read.
module fwrisc_fetch
  import fwrisc_fetch_pkg::*;
#(
  parameter bit ENABLE_COMPRESSED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_seq,
  input  logic        instr_complete,
  output logic [31:0] iaddr,
  output logic        ivalid,
  input  logic [31:0] idata,
  input  logic        iready,
  output logic [31:0] instr,
  output logic        instr_c,
  output logic        fetch_valid
);

  fetch_state_e state, state_nxt;

  logic        hold_valid;
  logic [15:0] hold;
  logic [29:0] hold_addr;
  logic [15:0] low;

  logic        hold_hit;
  logic        xfer;
  logic [15:0] half;
  logic        unused_pc0;

  // Halfwords only need bit 1 of the PC; bit 0 is always zero.
  assign unused_pc0 = pc[0];

  // Upper half of the current word is already buffered from the last fetch.
  assign hold_hit = ENABLE_COMPRESSED && pc_seq && hold_valid && pc[1]
                    && (hold_addr == pc[31:2]);
  assign xfer     = ivalid && iready;
  assign half     = hold_hit ? hold : (pc[1] ? idata[31:16] : idata[15:0]);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (!ENABLE_COMPRESSED) begin
          if (xfer) state_nxt = WAIT_DECODE;
        end else if (hold_hit || xfer) begin
          if (pc[1] && is_32bit(half)) state_nxt = FETCH2;
          else                         state_nxt = WAIT_DECODE;
        end
      end
      FETCH2:      if (xfer) state_nxt = WAIT_DECODE;
      WAIT_DECODE: if (instr_complete) state_nxt = FETCH;
      default:     state_nxt = FETCH;
    endcase
  end

  // Bus request and decode-valid outputs; ivalid drops the moment reset rises
  always_comb begin
    ivalid      = 1'b0;
    iaddr       = {pc[31:2], 2'b00};
    fetch_valid = (state == WAIT_DECODE);
    case (state)
      FETCH:  ivalid = !hold_hit;
      FETCH2: begin
        ivalid = 1'b1;
        iaddr  = {pc[31:2] + 30'd1, 2'b00};
      end
      default: ;
    endcase
    if (reset) ivalid = 1'b0;
  end

  // Instruction, low-half and hold-buffer capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr      <= '0;
      instr_c    <= 1'b0;
      hold_valid <= 1'b0;
      hold       <= '0;
      hold_addr  <= '0;
      low        <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!ENABLE_COMPRESSED) begin
            if (xfer) begin
              instr   <= idata;
              instr_c <= 1'b0;
            end
          end else if (!pc[1]) begin
            // hold_hit needs pc[1], so only a bus transfer lands here
            if (xfer) begin
              if (is_32bit(idata[15:0])) begin
                instr   <= idata;
                instr_c <= 1'b0;
              end else begin
                instr      <= {16'h0, idata[15:0]};
                instr_c    <= 1'b1;
                hold       <= idata[31:16];
                hold_addr  <= pc[31:2];
                hold_valid <= 1'b1;
              end
            end
          end else if (hold_hit || xfer) begin
            if (is_32bit(half)) begin
              low <= half;
            end else begin
              instr   <= {16'h0, half};
              instr_c <= 1'b1;
            end
          end
        end
        FETCH2: begin
          if (xfer) begin
            instr      <= {idata[15:0], low};
            instr_c    <= 1'b0;
            hold       <= idata[31:16];
            hold_addr  <= pc[31:2] + 30'd1;
            hold_valid <= 1'b1;
          end
        end
        WAIT_DECODE: begin
          // A jump may land in a word whose contents the buffer does not track
          if (instr_complete && !pc_seq) hold_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_fetch.sv
// Scoreboard bench for fwrisc_fetch: a lazily-filled memory model supplies
// bus data; expected instructions and bus-transfer counts are derived from
// memory halfwords and queued when the PC is issued, and a monitor pops and
// compares whenever fetch_valid rises.
module tb_fwrisc_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_seq = 1'b0;
  logic        instr_complete = 1'b0;
  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] idata = '0;
  logic        iready = 1'b0;
  logic [31:0] instr;
  logic        instr_c;
  logic        fetch_valid;

  fwrisc_fetch dut (
    .clock(clock), .reset(reset), .pc(pc), .pc_seq(pc_seq),
    .instr_complete(instr_complete), .iaddr(iaddr), .ivalid(ivalid),
    .idata(idata), .iready(iready), .instr(instr), .instr_c(instr_c),
    .fetch_valid(fetch_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic        c;
    int          ntr;
  } exp_t;

  exp_t         q[$];
  exp_t         me;
  bit [31:0]    mem [bit [29:0]];
  int           checks = 0, errors = 0;
  int           cyc = 0, last_x = 0, enter_cyc = 0, xfer_cnt = 0;
  int           mode = 0;           // 0 always ready, 1 random waits, 2 stalled
  bit           aborted = 0;
  bit           pend = 0;
  logic [31:0]  pend_addr = '0;
  logic         fv_q = 1'b0;
  bit           buf_valid = 0;      // model: word whose upper half is buffered
  bit [29:0]    buf_word = '0;
  logic         last_c = 1'b0;

  function automatic bit [15:0] rand_half();
    bit [15:0] h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else                           h[1:0] = 2'($urandom_range(0, 2));
    return h;
  endfunction

  function automatic bit [31:0] get_word(bit [29:0] a);
    if (!mem.exists(a)) mem[a] = {rand_half(), rand_half()};
    return mem[a];
  endfunction

  function automatic bit [15:0] hw(bit [31:0] a);
    bit [31:0] w = get_word(a[31:2]);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: instruction from memory halfwords; transfers = one word read
  // unless the buffered upper half is reused, plus one more for a straddle.
  task automatic push_exp(bit [31:0] npc, bit seq);
    exp_t      e;
    bit [15:0] h0 = hw(npc);
    bit        hit;
    if (!seq) buf_valid = 0;
    hit = seq && npc[1] && buf_valid && (buf_word == npc[31:2]);
    if (h0[1:0] == 2'b11) begin
      e.instr = {hw(npc + 32'd2), h0};
      e.c     = 1'b0;
    end else begin
      e.instr = {16'h0, h0};
      e.c     = 1'b1;
    end
    e.ntr = (hit ? 0 : 1) + ((npc[1] && !e.c) ? 1 : 0);
    if (!npc[1] && e.c) begin
      buf_valid = 1; buf_word = npc[31:2];
    end else if (npc[1] && !e.c) begin
      buf_valid = 1; buf_word = npc[31:2] + 30'd1;
    end
    last_c = e.c;
    q.push_back(e);
  endtask

  // Bus responder data/ready, driven away from the sampling edge
  always @(negedge clock) begin
    case (mode)
      0:       iready = 1'b1;
      1:       iready = ($urandom_range(0, 3) != 0);
      default: iready = 1'b0;
    endcase
    idata = ivalid ? get_word(iaddr[31:2]) : $urandom;
  end

  // Bus-side checks at the active edge: held requests, transfer addresses
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      pend = 0;
    end else begin
      if (pend) begin
        chk("req_held_ivalid", {31'b0, ivalid}, 32'd1);
        chk("req_held_iaddr", iaddr, pend_addr);
      end
      if (instr_complete) enter_cyc = cyc;
      if (ivalid && iready) begin
        last_x = cyc;
        xfer_cnt++;
        chk("xfer_addr", {31'b0, (iaddr[1:0] == 2'b00) &&
            (iaddr[31:2] == pc[31:2] || iaddr[31:2] == pc[31:2] + 30'd1)}, 32'd1);
      end
      pend      = ivalid && !iready;
      pend_addr = iaddr;
    end
  end

  // Monitor: pop and compare on each rising fetch_valid
  always @(negedge clock) begin
    if (reset) begin
      fv_q = 1'b0;
    end else begin
      if (fetch_valid && !fv_q) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got fetch_valid with no expected entry");
        end else begin
          me = q.pop_front();
          chk("instr", instr, me.instr);
          chk("instr_c", {31'b0, instr_c}, {31'b0, me.c});
          chk("bus_xfers", xfer_cnt, me.ntr);
          chk("latency", cyc, (me.ntr > 0) ? last_x : enter_cyc + 1);
          chk("idle_in_wait", {31'b0, ivalid}, 32'd0);
        end
        xfer_cnt = 0;
      end
      fv_q = fetch_valid;
    end
  end

  task automatic wait_fv();
    int n = 0;
    while (!fetch_valid && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!fetch_valid) begin
      checks++; errors++;
      $display("FAIL fetch_valid_timeout: got 0 expected 1 at pc %h", pc);
      aborted = 1;
    end
  endtask

  task automatic next_instr(bit [31:0] npc, bit seq, bit push = 1'b1);
    wait_fv();
    if (aborted) return;
    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    pc     = npc;
    pc_seq = seq;
    if (push) push_exp(npc, seq);
    instr_complete = 1'b1;
    @(posedge clock); #1;
    instr_complete = 1'b0;
  endtask

  initial begin
    bit [31:0] seqpc;
    int        r;
    mem[30'h2000_0000] = 32'h0000_0093;  // addi
    mem[30'h2000_0001] = 32'h4505_4501;  // two compressed
    mem[30'h2000_0004] = 32'h0093_1111;  // straddle low half in upper
    mem[30'h2000_0005] = 32'h5555_0000;
    mem[30'h2000_0008] = 32'h0513_4501;  // compressed then straddling 32-bit
    mem[30'h2000_0009] = 32'h1234_0000;
    mem[30'h3FFF_FFFF] = 32'h0013_0000;  // straddle across address wrap
    mem[30'h0000_0000] = 32'hABCD_0001;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_ivalid", {31'b0, ivalid}, 32'd0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_c", {31'b0, instr_c}, 32'd0);

    pc = 32'h8000_0000; pc_seq = 1'b0;
    push_exp(pc, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    next_instr(32'h8000_0004, 1'b1);   // compressed, fills hold
    next_instr(32'h8000_0006, 1'b1);   // hold hit, no bus
    next_instr(32'h8000_0006, 1'b0);   // jump: hold dropped, refetch
    next_instr(32'h8000_0012, 1'b0);   // straddling 32-bit
    next_instr(32'h8000_0016, 1'b1);   // hit on half left by FETCH2
    next_instr(32'hFFFF_FFFE, 1'b0);   // straddle wrapping to 0
    next_instr(32'h8000_0020, 1'b0);
    next_instr(32'h8000_0022, 1'b1);   // hit low half of a straddle

    mode = 1;
    for (int i = 0; i < 300 && !aborted; i++) begin
      r     = $urandom_range(0, 9);
      seqpc = pc + (last_c ? 32'd2 : 32'd4);
      if (r < 6)      next_instr(seqpc, 1'b1);
      else if (r < 8) next_instr(32'h9000_0000 + 32'($urandom_range(0, 31)) * 2, 1'b0);
      else            next_instr(seqpc, 1'b0);
    end

    if (!aborted) begin
      wait_fv();
      @(negedge clock); #1;
      chk("sb_drained", q.size(), 32'd0);
      mode = 2;
      @(posedge clock); #1;
      next_instr(32'hA000_0000, 1'b0, 1'b0);
      repeat (5) begin @(posedge clock); #1; end
      chk("stall_ivalid", {31'b0, ivalid}, 32'd1);
      chk("stall_iaddr", iaddr, 32'hA000_0000);
      #2 reset = 1'b1;
      #1;
      chk("midrst_ivalid", {31'b0, ivalid}, 32'd0);
      chk("midrst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
      chk("midrst_instr", instr, 32'd0);
      chk("midrst_instr_c", {31'b0, instr_c}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
